// File: rtl/score_if.sv
// Event, control and display signals of the BCD score keeper, grouped so the
// game datapath and the display side can connect through a single port.
interface score_if #(
  parameter int DIGITS = 4
);
  logic                  ev_valid;
  logic [1:0]            ev_code;
  logic                  ev_ready;
  logic                  game_over;
  logic [4*DIGITS-1:0]   score;
  logic [4*DIGITS-1:0]   hiscore;
  logic                  extra_life;
  logic                  overflow;

  // Game logic side: raises events and game over, watches the score.
  modport master (
    output ev_valid, ev_code, game_over,
    input  ev_ready, score, hiscore, extra_life, overflow
  );

  // Score keeper side.
  modport slave (
    input  ev_valid, ev_code, game_over,
    output ev_ready, score, hiscore, extra_life, overflow
  );
endinterface

// File: rtl/score_accumulator.sv
// Packed-BCD score keeper. Scoring events add a two-digit BCD addend to the
// score one digit per cycle, so no binary-to-BCD stage is needed for display.
// Overflow of the top digit either saturates at all-9s or wraps. Game over
// commits the high score and clears the score.
module score_accumulator #(
  parameter int DIGITS      = 4,
  parameter int PTS_DIAMOND = 5,
  parameter int PTS_BAG     = 10,
  parameter int PTS_GOBLIN  = 15,
  parameter int WRAP        = 0,
  parameter int BONUS_DIGIT = 3
) (
  input logic    clk,
  input logic    rst,
  score_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);

  // Two-digit BCD form of a 0..99 point value: {tens, units}.
  function automatic logic [7:0] to_bcd2(input int value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

  localparam logic [7:0] ADD_DIAMOND = to_bcd2(PTS_DIAMOND);
  localparam logic [7:0] ADD_BAG     = to_bcd2(PTS_BAG);
  localparam logic [7:0] ADD_GOBLIN  = to_bcd2(PTS_GOBLIN);
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    COMMIT,
    CLEAR
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [W-1:0]     r_score;
  logic [W-1:0]     r_hiscore;
  logic [W-1:0]     r_work;
  logic [7:0]       r_addend;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_pending;
  logic             r_overflow;
  logic             r_extra_life;

  logic             w_ready;
  logic             w_accept;
  logic             w_go;
  logic [7:0]       w_ev_addend;
  logic [3:0]       w_work_digit;
  logic [3:0]       w_add_digit;
  logic [4:0]       w_sum;
  logic [3:0]       w_new_digit;
  logic             w_last_digit;
  logic [W-1:0]     w_commit_score;
  logic             w_bonus;

  // A game over is in effect if one is waiting or one arrives this cycle.
  assign w_go         = r_pending | bus.game_over;
  assign w_accept     = bus.ev_valid & w_ready & (bus.ev_code != 2'b00);
  assign w_last_digit = (r_idx == IDX_W'(DIGITS - 1));

  // Only the two lowest addend digits can be non-zero.
  assign w_work_digit = r_work[4*r_idx +: 4];
  assign w_add_digit  = (r_idx == IDX_W'(0)) ? r_addend[3:0] :
                        (r_idx == IDX_W'(1)) ? r_addend[7:4] : 4'd0;
  assign w_sum        = {1'b0, w_work_digit} + {1'b0, w_add_digit} + {4'd0, r_carry};
  assign w_new_digit  = (w_sum > 5'd9) ? 4'(w_sum - 5'd10) : w_sum[3:0];

  // A carry out of the top digit saturates unless wrapping is selected.
  assign w_commit_score = (r_carry && (WRAP == 0)) ? ALL_NINES : r_work;
  assign w_bonus = (r_score[W-1:4*BONUS_DIGIT] != w_commit_score[W-1:4*BONUS_DIGIT])
                 | (r_carry && (WRAP != 0));

  // Event code to addend lookup.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_ev_addend = 8'd0;
    case (bus.ev_code)
      2'b01:   w_ev_addend = ADD_DIAMOND;
      2'b10:   w_ev_addend = ADD_BAG;
      2'b11:   w_ev_addend = ADD_GOBLIN;
      default: w_ev_addend = 8'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode and handshake ready; game over beats a waiting event.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = ~w_go;
        if (w_go)          w_next_state = CLEAR;
        else if (w_accept) w_next_state = ADD;
      end
      ADD:    if (w_last_digit) w_next_state = COMMIT;
      COMMIT: w_next_state = w_go ? CLEAR : IDLE;
      CLEAR:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: digit-serial BCD add, commit of the result, high-score update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score      <= '0;
      r_hiscore    <= '0;
      r_work       <= '0;
      r_addend     <= '0;
      r_carry      <= 1'b0;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_overflow   <= 1'b0;
      r_extra_life <= 1'b0;
    end else begin
      r_extra_life <= 1'b0;
      // A game over landing on the CLEAR cycle itself still starts another clear.
      r_pending    <= (r_state == CLEAR) ? bus.game_over : (r_pending | bus.game_over);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addend <= w_ev_addend;
            r_work   <= r_score;
            r_idx    <= '0;
            r_carry  <= 1'b0;
          end
        end
        ADD: begin
          r_work[4*r_idx +: 4] <= w_new_digit;
          r_carry              <= (w_sum > 5'd9);
          r_idx                <= r_idx + IDX_W'(1);
        end
        COMMIT: begin
          r_score      <= w_commit_score;
          r_extra_life <= w_bonus;
          if (r_carry) r_overflow <= 1'b1;
        end
        CLEAR: begin
          if (r_score > r_hiscore) r_hiscore <= r_score;
          r_score    <= '0;
          r_overflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ev_ready   = w_ready;
  assign bus.score      = r_score;
  assign bus.hiscore    = r_hiscore;
  assign bus.extra_life = r_extra_life;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator: a saturating and a wrapping instance
// receive identical stimulus; expected values are hand-computed BCD constants.
module tb_score_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  score_if #(.DIGITS(4)) a_if ();
  score_if #(.DIGITS(4)) b_if ();

  score_accumulator #(.DIGITS(4), .WRAP(0)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  score_accumulator #(.DIGITS(4), .WRAP(1)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  // Both instances always see the same inputs.
  task automatic drive(input logic valid, input logic [1:0] code, input logic go);
    a_if.ev_valid  = valid;
    a_if.ev_code   = code;
    a_if.game_over = go;
    b_if.ev_valid  = valid;
    b_if.ev_code   = code;
    b_if.game_over = go;
  endtask

  // Offer one event, hold it until accepted, drop valid after the accept edge.
  task automatic send_event(input logic [1:0] code);
    int n;
    n = 0;
    @(negedge clk);
    drive(1'b1, code, 1'b0);
    while (a_if.ev_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: ev_ready stayed %b, required 1", a_if.ev_ready);
    end
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b0);
  endtask

  // Event plus wait until its COMMIT edge has passed.
  task automatic add_and_wait(input logic [1:0] code);
    send_event(code);
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_game_over();
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b00, 1'b0);
    rst = 1'b1;
    #12;
    total++;
    if (a_if.score !== 16'h0000 || a_if.hiscore !== 16'h0000 ||
        a_if.overflow !== 1'b0 || a_if.extra_life !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: score=%h hi=%h ov=%b el=%b, required 0000 0000 0 0",
               a_if.score, a_if.hiscore, a_if.overflow, a_if.extra_life);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (a_if.ev_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: ev_ready=%b, required 1", a_if.ev_ready);
    end
  endtask

  // Diamond, bag, goblin with ev_valid held high throughout.
  task automatic test_back_to_back();
    logic [1:0]  codes [3];
    logic [15:0] exp   [3];
    int lows;
    codes = '{2'b01, 2'b10, 2'b11};
    exp   = '{16'h0005, 16'h0015, 16'h0030};
    @(negedge clk);
    drive(1'b1, codes[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lows = 0;
      for (int k = 0; k < 5; k++) begin
        if (a_if.ev_ready === 1'b0) lows++;
        if (k == 0 && i < 2) drive(1'b1, codes[i+1], 1'b0);
        @(negedge clk);
      end
      total++;
      if (lows != 5 || a_if.ev_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready[%0d]: low cycles=%0d ready_after=%b, required 5 and 1",
                 i, lows, a_if.ev_ready);
      end
      total++;
      if (a_if.score !== exp[i]) begin
        bad++;
        $display("FAIL b2b_score[%0d]: score=%h, required %h", i, a_if.score, exp[i]);
      end
      if (i == 2) drive(1'b0, 2'b00, 1'b0);
    end
  endtask

  task automatic test_hiscore();
    pulse_game_over();
    @(negedge clk);
    total++;
    if (a_if.hiscore !== 16'h0030 || a_if.score !== 16'h0000) begin
      bad++;
      $display("FAIL hiscore_commit: hi=%h score=%h, required 0030 0000", a_if.hiscore, a_if.score);
    end
    add_and_wait(2'b10);
    add_and_wait(2'b10);
    total++;
    if (a_if.score !== 16'h0020) begin
      bad++;
      $display("FAIL second_game_score: score=%h, required 0020", a_if.score);
    end
    pulse_game_over();
    @(negedge clk);
    total++;
    if (a_if.hiscore !== 16'h0030 || a_if.score !== 16'h0000) begin
      bad++;
      $display("FAIL hiscore_keep: hi=%h score=%h, required 0030 0000", a_if.hiscore, a_if.score);
    end
  endtask

  // game_over arrives during the second ADD cycle and must wait for COMMIT.
  task automatic test_pending_game_over();
    repeat (4) add_and_wait(2'b10);
    total++;
    if (a_if.score !== 16'h0040) begin
      bad++;
      $display("FAIL pending_setup: score=%h, required 0040", a_if.score);
    end
    send_event(2'b10);
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (a_if.score !== 16'h0040 || a_if.ev_ready !== 1'b0) begin
      bad++;
      $display("FAIL pending_mid_add: score=%h ready=%b, required 0040 0", a_if.score, a_if.ev_ready);
    end
    @(negedge clk);
    total++;
    if (a_if.score !== 16'h0050 || a_if.hiscore !== 16'h0030 || a_if.ev_ready !== 1'b0) begin
      bad++;
      $display("FAIL pending_commit: score=%h hi=%h ready=%b, required 0050 0030 0",
               a_if.score, a_if.hiscore, a_if.ev_ready);
    end
    @(negedge clk);
    total++;
    if (a_if.score !== 16'h0000 || a_if.hiscore !== 16'h0050 || a_if.ev_ready !== 1'b1) begin
      bad++;
      $display("FAIL pending_clear: score=%h hi=%h ready=%b, required 0000 0050 1",
               a_if.score, a_if.hiscore, a_if.ev_ready);
    end
  endtask

  task automatic test_extra_life();
    for (int i = 0; i < 66; i++) add_and_wait(2'b11);
    add_and_wait(2'b01);
    total++;
    if (a_if.score !== 16'h0995) begin
      bad++;
      $display("FAIL bonus_setup: score=%h, required 0995", a_if.score);
    end
    send_event(2'b10);
    repeat (4) @(negedge clk);
    total++;
    if (a_if.extra_life !== 1'b0 || a_if.score !== 16'h0995) begin
      bad++;
      $display("FAIL bonus_early: el=%b score=%h, required 0 0995", a_if.extra_life, a_if.score);
    end
    @(negedge clk);
    total++;
    if (a_if.extra_life !== 1'b1 || a_if.score !== 16'h1005) begin
      bad++;
      $display("FAIL bonus_pulse: el=%b score=%h, required 1 1005", a_if.extra_life, a_if.score);
    end
    @(negedge clk);
    total++;
    if (a_if.extra_life !== 1'b0) begin
      bad++;
      $display("FAIL bonus_width: el=%b, required 0", a_if.extra_life);
    end
    add_and_wait(2'b01);
    total++;
    if (a_if.extra_life !== 1'b0 || a_if.score !== 16'h1010) begin
      bad++;
      $display("FAIL bonus_none: el=%b score=%h, required 0 1010", a_if.extra_life, a_if.score);
    end
    pulse_game_over();
    @(negedge clk);
    total++;
    if (a_if.hiscore !== 16'h1010 || a_if.score !== 16'h0000) begin
      bad++;
      $display("FAIL bonus_hiscore: hi=%h score=%h, required 1010 0000", a_if.hiscore, a_if.score);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 666; i++) add_and_wait(2'b11);
    add_and_wait(2'b01);
    total++;
    if (a_if.score !== 16'h9995 || b_if.score !== 16'h9995 || a_if.overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_setup: sat=%h wrap=%h ov=%b, required 9995 9995 0",
               a_if.score, b_if.score, a_if.overflow);
    end
    add_and_wait(2'b11);
    total++;
    if (a_if.score !== 16'h9999 || a_if.overflow !== 1'b1 || a_if.extra_life !== 1'b0) begin
      bad++;
      $display("FAIL ovf_saturate: score=%h ov=%b el=%b, required 9999 1 0",
               a_if.score, a_if.overflow, a_if.extra_life);
    end
    total++;
    if (b_if.score !== 16'h0010 || b_if.overflow !== 1'b1 || b_if.extra_life !== 1'b1) begin
      bad++;
      $display("FAIL ovf_wrap: score=%h ov=%b el=%b, required 0010 1 1",
               b_if.score, b_if.overflow, b_if.extra_life);
    end
    repeat (3) @(negedge clk);
    total++;
    if (a_if.overflow !== 1'b1 || b_if.overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: sat=%b wrap=%b, required 1 1", a_if.overflow, b_if.overflow);
    end
    pulse_game_over();
    @(negedge clk);
    total++;
    if (a_if.overflow !== 1'b0 || a_if.hiscore !== 16'h9999 ||
        b_if.overflow !== 1'b0 || b_if.hiscore !== 16'h1010) begin
      bad++;
      $display("FAIL ovf_clear: sat ov=%b hi=%h wrap ov=%b hi=%h, required 0 9999 0 1010",
               a_if.overflow, a_if.hiscore, b_if.overflow, b_if.hiscore);
    end
  endtask

  // Asynchronous reset mid-ADD, then an ignored code-00 event.
  task automatic test_async_reset();
    add_and_wait(2'b10);
    send_event(2'b11);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (a_if.score !== 16'h0000 || a_if.hiscore !== 16'h0000 ||
        a_if.overflow !== 1'b0 || a_if.extra_life !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: score=%h hi=%h ov=%b el=%b, required 0000 0000 0 0",
               a_if.score, a_if.hiscore, a_if.overflow, a_if.extra_life);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (a_if.ev_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_ready: ev_ready=%b, required 1", a_if.ev_ready);
    end
    repeat (6) @(negedge clk);
    drive(1'b1, 2'b00, 1'b0);
    @(negedge clk);
    total++;
    if (a_if.ev_ready !== 1'b1) begin
      bad++;
      $display("FAIL null_ready: ev_ready=%b, required 1", a_if.ev_ready);
    end
    drive(1'b0, 2'b00, 1'b0);
    repeat (6) @(negedge clk);
    total++;
    if (a_if.score !== 16'h0000 || a_if.ev_ready !== 1'b1 || a_if.extra_life !== 1'b0) begin
      bad++;
      $display("FAIL null_event: score=%h ready=%b el=%b, required 0000 1 0",
               a_if.score, a_if.ev_ready, a_if.extra_life);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hiscore();
    test_pending_game_over();
    test_extra_life();
    test_overflow();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
